// File: rtl/tankb_pkg.sv
// Shared types and default sizes for the VRAM arbiter.
// Holds the FSM state enum, the owner enum and default AW/DW.
package tankb_pkg;

  localparam int VRAM_AW = 11;
  localparam int VRAM_DW = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    CAPTURE
  } state_e;

  typedef enum logic {
    OWN_DISP,
    OWN_CPU
  } owner_e;

endpackage

// File: rtl/vram_arbiter.sv
// Two-master arbiter (display fetch, CPU) onto one sync single-port RAM.
// Ports: CLK_18M/RESET_n, disp_* fetch side, cpu_* access side, ram_* RAM side.
module vram_arbiter
  import tankb_pkg::*;
#(
  parameter int AW = VRAM_AW,
  parameter int DW = VRAM_DW
) (
  input  logic          CLK_18M,
  input  logic          RESET_n,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic [DW-1:0] disp_data,
  output logic          disp_valid,
  output logic          disp_ovf,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_din,
  output logic [DW-1:0] cpu_dout,
  output logic          cpu_ack,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_we,
  input  logic [DW-1:0] ram_dout
);

  state_e        state_q;
  owner_e        owner_q;
  logic          wr_q;

  logic          dpend_q;
  logic [AW-1:0] daddr_q;
  logic          cpend_q;
  logic          cwe_q;
  logic [AW-1:0] caddr_q;
  logic [DW-1:0] cdin_q;

  logic grant;
  logic grant_disp;
  logic grant_cpu;
  logic cpu_busy;

  // A new access may start from IDLE or overlap the CAPTURE cycle.
  assign grant      = (state_q != ISSUE) && (dpend_q || cpend_q);
  assign grant_disp = grant && dpend_q;
  assign grant_cpu  = grant && !dpend_q;

  // CPU side takes one request at a time, including its ack cycle.
  assign cpu_busy = cpend_q || cpu_ack ||
                    ((state_q != IDLE) && (owner_q == OWN_CPU));

  always_ff @(posedge CLK_18M or negedge RESET_n) begin
    if (!RESET_n) begin
      dpend_q  <= 1'b0;
      daddr_q  <= '0;
      disp_ovf <= 1'b0;
    end else if (disp_req) begin
      dpend_q <= 1'b1;
      daddr_q <= disp_addr;
      // Overwrite of a request that is not leaving at this edge.
      if (dpend_q && !grant_disp) disp_ovf <= 1'b1;
    end else if (grant_disp) begin
      dpend_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK_18M or negedge RESET_n) begin
    if (!RESET_n) begin
      cpend_q <= 1'b0;
      cwe_q   <= 1'b0;
      caddr_q <= '0;
      cdin_q  <= '0;
    end else if (cpu_req && !cpu_busy) begin
      cpend_q <= 1'b1;
      cwe_q   <= cpu_we;
      caddr_q <= cpu_addr;
      cdin_q  <= cpu_din;
    end else if (grant_cpu) begin
      cpend_q <= 1'b0;
    end
  end

  always_ff @(posedge CLK_18M or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q    <= IDLE;
      owner_q    <= OWN_DISP;
      wr_q       <= 1'b0;
      ram_addr   <= '0;
      ram_din    <= '0;
      ram_we     <= 1'b0;
      disp_data  <= '0;
      disp_valid <= 1'b0;
      cpu_dout   <= '0;
      cpu_ack    <= 1'b0;
    end else begin
      disp_valid <= 1'b0;
      cpu_ack    <= 1'b0;
      unique case (state_q)
        IDLE: begin
          state_q <= grant ? ISSUE : IDLE;
        end
        ISSUE: begin
          state_q <= CAPTURE;
          ram_we  <= 1'b0;
        end
        CAPTURE: begin
          if (owner_q == OWN_DISP) begin
            disp_data  <= ram_dout;
            disp_valid <= 1'b1;
          end else begin
            if (!wr_q) cpu_dout <= ram_dout;
            cpu_ack <= 1'b1;
          end
          state_q <= grant ? ISSUE : IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (grant) begin
        owner_q  <= grant_disp ? OWN_DISP : OWN_CPU;
        wr_q     <= grant_cpu && cwe_q;
        ram_addr <= grant_disp ? daddr_q : caddr_q;
        ram_we   <= grant_cpu && cwe_q;
        if (grant_cpu) ram_din <= cdin_q;
      end
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter with a sync RAM model.
// Directed scenarios plus a randomized stress run against a shadow RAM.
module tb_vram_arbiter;

  localparam int AW = 11;
  localparam int DW = 8;
  localparam int NREQ = 1000;

  logic          CLK_18M = 1'b0;
  logic          RESET_n = 1'b0;
  logic          disp_req = 1'b0;
  logic [AW-1:0] disp_addr = '0;
  logic [DW-1:0] disp_data;
  logic          disp_valid;
  logic          disp_ovf;
  logic          cpu_req = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_din = '0;
  logic [DW-1:0] cpu_dout;
  logic          cpu_ack;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din;
  logic          ram_we;
  logic [DW-1:0] ram_dout = '0;

  int nchk = 0;
  int nerr = 0;

  logic          clr = 1'b1;
  logic [DW-1:0] mem    [2**AW];
  logic          wrt    [2**AW];
  logic [DW-1:0] shadow [2**AW];

  always #5 CLK_18M = ~CLK_18M;

  vram_arbiter #(.AW(AW), .DW(DW)) dut (
    .CLK_18M   (CLK_18M),
    .RESET_n   (RESET_n),
    .disp_req  (disp_req),
    .disp_addr (disp_addr),
    .disp_data (disp_data),
    .disp_valid(disp_valid),
    .disp_ovf  (disp_ovf),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_din   (cpu_din),
    .cpu_dout  (cpu_dout),
    .cpu_ack   (cpu_ack),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_we    (ram_we),
    .ram_dout  (ram_dout)
  );

  function automatic logic [7:0] init_val(input logic [10:0] a);
    logic [7:0] t;
    if (a == 11'h123) return 8'hA5;
    t = a[7:0];
    return (t * 8'd37) ^ 8'h5C;
  endfunction

  // Sync RAM: registered read, write on ram_we.
  always @(posedge CLK_18M) begin
    if (clr) begin
      for (int i = 0; i < 2**AW; i++) wrt[i] <= 1'b0;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_din;
      wrt[ram_addr] <= 1'b1;
    end
    ram_dout <= wrt[ram_addr] ? mem[ram_addr] : init_val(ram_addr);
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK_18M);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_we"}, {31'd0, ram_we}, 0);
    chk({tag, "_addr"}, {21'd0, ram_addr}, 0);
    chk({tag, "_din"}, {24'd0, ram_din}, 0);
    chk({tag, "_ddata"}, {24'd0, disp_data}, 0);
    chk({tag, "_cdout"}, {24'd0, cpu_dout}, 0);
    chk({tag, "_dvalid"}, {31'd0, disp_valid}, 0);
    chk({tag, "_ack"}, {31'd0, cpu_ack}, 0);
    chk({tag, "_ovf"}, {31'd0, disp_ovf}, 0);
  endtask

  task automatic cpu_op(input logic we, input logic [10:0] a,
                        input logic [7:0] d, output logic [7:0] q,
                        output int n_ack, output int n_we,
                        output logic [10:0] we_a);
    q = '0; n_ack = 0; n_we = 0; we_a = '0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_din = d;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ram_we) begin n_we++; we_a = ram_addr; end
      if (cpu_ack) begin n_ack++; q = cpu_dout; cpu_req = 1'b0; end
    end
    cpu_req = 1'b0;
  endtask

  initial begin
    logic [7:0]  q;
    logic [10:0] wa;
    int          na, nw, dv_n, ack_n, nv, lat, cyc;
    int          dqa[$], dqt[$];
    int          d_iss, d_done, c_iss, c_done, dgap;
    logic        cbusy, cwe;
    logic [10:0] ca;
    logic [7:0]  cd;

    for (int i = 0; i < 2**AW; i++) shadow[i] = init_val(11'(i));

    // Reset values
    tick(); tick();
    chk_reset("rst");
    clr = 1'b0;
    tick();
    RESET_n = 1'b1;

    // Idle display read, first edge after reset release
    disp_req = 1'b1; disp_addr = 11'h123;
    tick();
    disp_req = 1'b0;
    for (int n = 1; n <= 5; n++) begin
      tick();
      chk($sformatf("idle_valid_e%0d", n), {31'd0, disp_valid}, (n == 3));
      if (n == 3) chk("idle_data", {24'd0, disp_data}, 32'hA5);
    end

    // CPU write then read back
    cpu_op(1'b1, 11'h400, 8'h5A, q, na, nw, wa);
    shadow[11'h400] = 8'h5A;
    chk("wr_acks", na, 1);
    chk("wr_we_pulses", nw, 1);
    chk("wr_we_addr", {21'd0, wa}, 32'h400);
    chk("wr_dout_hold", {24'd0, cpu_dout}, 0);
    cpu_op(1'b0, 11'h400, 8'h00, q, na, nw, wa);
    chk("rd_acks", na, 1);
    chk("rd_we_pulses", nw, 0);
    chk("rd_data", {24'd0, q}, 32'h5A);

    // Simultaneous display and CPU read
    disp_req = 1'b1; disp_addr = 11'h010;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h020;
    tick();
    disp_req = 1'b0;
    dv_n = -1; ack_n = -1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      if (disp_valid) begin
        dv_n = n;
        chk("sim_ddata", {24'd0, disp_data}, {24'd0, shadow[11'h010]});
      end
      if (cpu_ack) begin
        ack_n = n; cpu_req = 1'b0;
        chk("sim_cdata", {24'd0, cpu_dout}, {24'd0, shadow[11'h020]});
      end
    end
    chk("sim_valid_edge", dv_n, 3);
    chk("sim_ack_edge", ack_n, 5);
    chk("sim_ovf", {31'd0, disp_ovf}, 0);

    // Overflow: second fetch arrives while first waits behind the CPU
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 11'h030;
    tick();
    disp_req = 1'b1; disp_addr = 11'h001;
    tick();
    disp_addr = 11'h002;
    tick();
    disp_req = 1'b0;
    nv = 0; na = 0; q = '0;
    for (int n = 0; n < 10; n++) begin
      if (disp_valid) begin nv++; q = disp_data; end
      if (cpu_ack) begin na++; cpu_req = 1'b0; end
      tick();
    end
    cpu_req = 1'b0;
    chk("ovf_valids", nv, 1);
    chk("ovf_data", {24'd0, q}, {24'd0, shadow[11'h002]});
    chk("ovf_flag", {31'd0, disp_ovf}, 1);
    chk("ovf_cpu_acks", na, 1);

    // Reset in the middle of a CPU write
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 11'h077; cpu_din = 8'hEE;
    nw = 0;
    for (int n = 0; n < 10 && nw == 0; n++) begin
      tick();
      if (ram_we) nw = 1;
    end
    chk("mid_we_seen", nw, 1);
    #2 RESET_n = 1'b0;
    #1 chk_reset("midrst");
    cpu_req = 1'b0; cpu_we = 1'b0;
    tick(); tick();
    RESET_n = 1'b1;
    na = 0;
    for (int n = 0; n < 6; n++) begin
      tick();
      if (cpu_ack) na++;
    end
    chk("midrst_no_ack", na, 0);
    chk("midrst_no_write", {31'd0, wrt[11'h077]}, 0);

    // Randomized stress against the shadow RAM
    d_iss = 0; d_done = 0; c_iss = 0; c_done = 0;
    cbusy = 1'b0; cwe = 1'b0; ca = '0; cd = '0;
    dgap = 10; cyc = 0;
    while (((d_iss + c_iss) < NREQ || dqa.size() != 0 || cbusy)
           && cyc < 20000) begin
      tick();
      cyc++;
      disp_req = 1'b0;
      dgap++;
      if (disp_valid) begin
        if (dqa.size() == 0) begin
          chk("st_spurious_valid", 1, 0);
        end else begin
          wa = 11'(dqa.pop_front());
          lat = cyc - dqt.pop_front();
          chk("st_ddata", {24'd0, disp_data}, {24'd0, shadow[wa]});
          chk("st_dlat_le5", {31'd0, lat <= 5}, 1);
          d_done++;
        end
      end
      if (cpu_ack) begin
        if (!cbusy) begin
          chk("st_spurious_ack", 1, 0);
        end else begin
          if (cwe) shadow[ca] = cd;
          else chk("st_cdata", {24'd0, cpu_dout}, {24'd0, shadow[ca]});
          c_done++;
        end
        cbusy = 1'b0;
        cpu_req = 1'b0;
      end
      if ((d_iss + c_iss) < NREQ && dgap >= 4 && $urandom_range(0, 2) == 0) begin
        disp_req = 1'b1;
        disp_addr = 11'($urandom_range(0, 15));
        dqa.push_back(int'(disp_addr));
        dqt.push_back(cyc + 1);
        d_iss++;
        dgap = 0;
      end
      if ((d_iss + c_iss) < NREQ && !cbusy && $urandom_range(0, 1) == 0) begin
        cwe = 1'($urandom_range(0, 1));
        ca = 11'($urandom_range(0, 15));
        cd = 8'($urandom);
        cpu_req = 1'b1; cpu_we = cwe; cpu_addr = ca; cpu_din = cd;
        cbusy = 1'b1;
        c_iss++;
      end
    end
    disp_req = 1'b0;
    cpu_req = 1'b0;
    chk("st_drained", dqa.size() + int'(cbusy), 0);
    chk("st_disp_count", d_done, d_iss);
    chk("st_cpu_count", c_done, c_iss);
    chk("st_no_ovf", {31'd0, disp_ovf}, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
